// File: rtl/parity_checker_if.sv
// Serial-bit input and decoded-word output bundle for parity_checker.
interface parity_checker_if #(
    parameter int unsigned DATA_W   = 3,
    parameter int unsigned ERRCNT_W = 8
);
    logic                bit_in;
    logic                bit_valid;
    logic                frame_abort;
    logic [DATA_W-1:0]   data_out;
    logic                data_valid;
    logic                parity_err;
    logic [ERRCNT_W-1:0] err_count;
    logic                busy;

    modport master (
        output bit_in, bit_valid, frame_abort,
        input  data_out, data_valid, parity_err, err_count, busy
    );

    modport slave (
        input  bit_in, bit_valid, frame_abort,
        output data_out, data_valid, parity_err, err_count, busy
    );
endinterface

// File: rtl/parity_checker.sv
// Serial parity checker: reassembles DATA_W data bits plus one parity bit,
// flags parity mismatches and keeps a saturating error count.
module parity_checker #(
    parameter int unsigned DATA_W     = 3,
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    parity_checker_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                parity_err_q, parity_err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                busy_q, busy_d;

    logic accept;
    logic frame_err;

    // Abort takes priority over a coincident bit in every state.
    assign accept    = bus.bit_valid && !bus.frame_abort;
    assign frame_err = acc_q ^ bus.bit_in ^ ODD_PARITY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            err_count_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            err_count_q  <= err_count_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.frame_abort) begin
            state_d = IDLE;
        end else if (bus.bit_valid) begin
            unique case (state_q)
                IDLE:    state_d = (DATA_W == 1) ? PAR : DATA;
                DATA:    state_d = (cnt_q == LAST_CNT) ? PAR : DATA;
                PAR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        err_count_d  = err_count_q;
        busy_d       = (state_d != IDLE);

        if (bus.frame_abort) begin
            shreg_d = '0;
            acc_d   = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            if (state_q == PAR) begin
                data_out_d   = shreg_q;
                parity_err_d = frame_err;
                data_valid_d = 1'b1;
                acc_d        = 1'b0;
                cnt_d        = '0;
                if (frame_err && (err_count_q != '1)) begin
                    err_count_d = err_count_q + 1'b1;
                end
            end else begin
                // Shift-based form keeps DATA_W=1 legal (no negative slice).
                shreg_d = (shreg_q << 1) | DATA_W'(bus.bit_in);
                acc_d   = acc_q ^ bus.bit_in;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_parity_checker.sv
// Drives one serial stream into three parity_checker variants (even/8-bit
// count, even/2-bit count, odd/8-bit count) and scoreboards every pulse.
module tb_parity_checker;
    logic clk = 1'b0;
    logic rst;
    logic bit_in, bit_valid, frame_abort;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;

    typedef struct {
        logic [2:0]  d;
        logic        e;
        int unsigned cnt;
        int unsigned at;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int unsigned mcnt [3];
    int unsigned cmax [3] = '{255, 3, 255};
    logic        oddp [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_checker_if #(.DATA_W(3), .ERRCNT_W(8)) if0 ();
    parity_checker_if #(.DATA_W(3), .ERRCNT_W(2)) if1 ();
    parity_checker_if #(.DATA_W(3), .ERRCNT_W(8)) if2 ();

    assign if0.bit_in = bit_in; assign if0.bit_valid = bit_valid; assign if0.frame_abort = frame_abort;
    assign if1.bit_in = bit_in; assign if1.bit_valid = bit_valid; assign if1.frame_abort = frame_abort;
    assign if2.bit_in = bit_in; assign if2.bit_valid = bit_valid; assign if2.frame_abort = frame_abort;

    parity_checker #(.DATA_W(3), .ODD_PARITY(1'b0), .ERRCNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    parity_checker #(.DATA_W(3), .ODD_PARITY(1'b0), .ERRCNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    parity_checker #(.DATA_W(3), .ODD_PARITY(1'b1), .ERRCNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_pulse(input int k, input logic [2:0] d, input logic e, input int unsigned c);
        exp_t x;
        int unsigned n;
        n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        chk($sformatf("dut%0d_pulse_expected", k), 32'(n != 0), 1);
        if (n != 0) begin
            if (k == 0) x = q0.pop_front();
            else if (k == 1) x = q1.pop_front();
            else x = q2.pop_front();
            chk($sformatf("dut%0d_data_out", k), 32'(d), 32'(x.d));
            chk($sformatf("dut%0d_parity_err", k), 32'(e), 32'(x.e));
            chk($sformatf("dut%0d_err_count", k), c, x.cnt);
            chk($sformatf("dut%0d_pulse_cycle", k), cyc, x.at);
        end
    endtask

    // Scoreboard consumer: every data_valid pulse must match a queued frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (if0.data_valid) check_pulse(0, if0.data_out, if0.parity_err, 32'(if0.err_count));
            if (if1.data_valid) check_pulse(1, if1.data_out, if1.parity_err, 32'(if1.err_count));
            if (if2.data_valid) check_pulse(2, if2.data_out, if2.parity_err, 32'(if2.err_count));
        end
    end

    task automatic push_frame(input logic [2:0] d, input logic p);
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            x.d = d;
            x.e = d[2] ^ d[1] ^ d[0] ^ p ^ oddp[k];
            if (x.e && mcnt[k] < cmax[k]) mcnt[k]++;
            x.cnt = mcnt[k];
            x.at  = cyc + 1;
            if (k == 0) q0.push_back(x);
            else if (k == 1) q1.push_back(x);
            else q2.push_back(x);
        end
    endtask

    task automatic drive(input logic b, input logic v, input logic a);
        bit_in = b;
        bit_valid = v;
        frame_abort = a;
        @(negedge clk);
    endtask

    task automatic gaps(input int unsigned maxgap, input bit check_busy);
        int unsigned g;
        g = (maxgap != 0) ? $urandom_range(maxgap, 0) : 0;
        repeat (g) begin
            drive(1'b0, 1'b0, 1'b0);
            if (check_busy) chk("busy_in_gap", 32'(if0.busy), 1);
        end
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input int unsigned maxgap);
        for (int i = 0; i < 3; i++) begin
            gaps(maxgap, i > 0);
            drive(d[2-i], 1'b1, 1'b0);
        end
        gaps(maxgap, 1'b1);
        push_frame(d, p);
        drive(p, 1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d0_data_out"}, 32'(if0.data_out), 0);
        chk({tag, "_d0_data_valid"}, 32'(if0.data_valid), 0);
        chk({tag, "_d0_parity_err"}, 32'(if0.parity_err), 0);
        chk({tag, "_d0_err_count"}, 32'(if0.err_count), 0);
        chk({tag, "_d0_busy"}, 32'(if0.busy), 0);
        chk({tag, "_d1_err_count"}, 32'(if1.err_count), 0);
        chk({tag, "_d2_data_out"}, 32'(if2.data_out), 0);
        chk({tag, "_d2_busy"}, 32'(if2.busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        rst = 1'b1;
        bit_in = 1'b0; bit_valid = 1'b0; frame_abort = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // basic even-parity frames, bit_valid held high
        send_frame(3'b101, 1'b0, 0);
        send_frame(3'b111, 1'b0, 0);
        send_frame(3'b011, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("d0_count_after_good", 32'(if0.err_count), 1);

        // random gaps
        send_frame(3'b110, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // abort mid-data together with a valid bit
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("busy_before_abort", 32'(if0.busy), 1);
        drive(1'b0, 1'b1, 1'b1);
        chk("busy_after_abort", 32'(if0.busy), 0);
        chk("data_out_held_after_abort", 32'(if0.data_out), 32'(3'b110));
        send_frame(3'b001, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b0);

        // abort on the parity bit
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        chk("busy_after_parity_abort", 32'(if0.busy), 0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // saturation of the 2-bit counter, back-to-back bad frames
        do_reset();
        repeat (5) send_frame(3'b111, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("d1_saturated", 32'(if1.err_count), 3);
        chk("d0_count_five", 32'(if0.err_count), 5);

        // odd-parity frame, then reset mid-frame
        send_frame(3'b101, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        do_reset();
        chk_zero("midreset");
        send_frame(3'b010, 1'b1, 0);
        send_frame(3'b100, 1'b0, 2);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/parity_checker.md
# parity_checker

Serial parity checker: the receive-side counterpart of the combinational parity generator. It takes a frame of DATA_W data bits followed by one parity bit on a single serial line (one bit per `bit_valid` strobe), reassembles the data word, and checks it against the selected parity sense. It flags mismatches and keeps a saturating error count. It sits at the far end of any link that carries generator-protected words serially, between the bit-level front end and word-level consumers.

## Interface
- `DATA_W`, 3, data bits per frame (≥1); 3 matches the generator's X/Y/Z word
- `ODD_PARITY`, 0, 0 = even parity (parity bit = XOR of data, as the generator produces), 1 = odd
- `ERRCNT_W`, 8, width of the saturating error counter (≥1)

- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `bit_in`  in  1  serial data/parity bit, sampled only when `bit_valid`=1
- `bit_valid`  in  1  qualifies `bit_in` for one cycle; may be held high for back-to-back bits or dropped for arbitrary gaps
- `frame_abort`  in  1  discards the frame in progress and resynchronises to a frame start
- `data_out`  out  DATA_W  last completed data word; first received bit lands in MSB
- `data_valid`  out  1  one-cycle pulse: `data_out`/`parity_err` updated for a new frame
- `parity_err`  out  1  parity result of last completed frame (1 = mismatch)
- `err_count`  out  ERRCNT_W  number of frames with `parity_err`=1 since reset, saturating at all-ones
- `busy`  out  1  high while a frame is partially received (≥1 bit accepted, parity not yet accepted)

## Operation
- FSM states: IDLE (no bits held), DATA (collecting data bits), PAR (all DATA_W data bits held, awaiting parity bit).
- IDLE + accepted bit: shift into the data shift register, XOR into the accumulator, and set bit count to 1. Go to DATA, or go directly to PAR if DATA_W=1.
- DATA + accepted bit: shift into the register and XOR into the accumulator, then increment the count. When the count reaches DATA_W, go to PAR.
- PAR + accepted bit: compute `err = acc ^ bit_in ^ ODD_PARITY`. Load `data_out` from the shift register and load `parity_err`. Pulse `data_valid`, clear the accumulator and count, and return to IDLE.
- Shift order: the register shifts left, with the new bit entering at LSB. After DATA_W bits, the first bit received is `data_out[DATA_W-1]`.
- `err_count`: increments in the cycle `data_valid` rises with `parity_err`=1, unless it is already all-ones (then it holds).
- `frame_abort`=1: return to IDLE and clear the accumulator, count and shift register. No `data_valid` pulse. `data_out`, `parity_err` and `err_count` keep their previous values.
- `frame_abort` and `bit_valid` in the same cycle: abort wins and the bit is dropped. This holds in every state, including PAR, so an aborted parity bit never produces `data_valid`.
- `bit_valid`=0: all state holds; gaps of any length are allowed at any position in the frame.
- Reset mid-frame: the partial frame is lost and every register returns to its reset value.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `err_count`=0, `busy`=0, FSM=IDLE, accumulator=0, count=0.
- Latency: `data_valid`, `data_out` and `parity_err` are registered. They are visible in the cycle after the edge that samples the parity bit, which is 1 clock after the parity bit is presented.
- `err_count` updates on the same edge as `data_valid` and `parity_err`.
- `data_valid` is high for exactly one cycle per completed frame.
- `data_out` and `parity_err` hold until the next completed frame.
- Back-to-back operation: the first bit of the next frame may be presented in the cycle after the parity bit. Full throughput is DATA_W+1 cycles per frame with `bit_valid` held high.
- `busy` is registered. It is 1 from the edge that accepts the first data bit until the edge that accepts the parity bit or an abort.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then even parity with DATA_W=3. Send bits 1,0,1 then parity 0, with `bit_valid` held high. Required: one cycle after the parity bit, `data_valid`=1, `data_out`=3'b101, `parity_err`=0, `err_count`=0.
- Send 1,1,1 then parity 0. Required: `data_out`=3'b111, `parity_err`=1, `err_count`=1. Then send 0,1,1 then parity 0. Required: `parity_err`=0 and `err_count` stays 1.
- Send frame 1,1,0,0 with random 0–5 cycle gaps on `bit_valid`. Required: a single `data_valid` pulse with `data_out`=3'b110 and `parity_err`=0. `busy`=1 throughout the gaps.
- Send 1,0, then assert `frame_abort` together with a `bit_valid`. Then send 0,0,1 with parity 1. Required: no pulse after the abort, `busy` drops, and the next pulse shows `data_out`=3'b001 with `parity_err`=0. Repeat with the abort on the parity bit: required no pulse.
- ERRCNT_W=2: send 5 bad frames back-to-back. Required: `err_count` sequence 1,2,3,3,3, with a pulse every 4 cycles.
- ODD_PARITY=1: send 1,0,1 then parity 1. Required: `parity_err`=0. Assert `rst` mid-frame after 2 bits. Required: all outputs 0 the next cycle, and the next full frame decodes correctly.
